uut_clk_ctrl: RTL

Parametrised UUT clock controller for the autotest harness. It sits between the autotest FSM and the unit under test. It produces a fabric-registered divided UUT clock with a matching one-cycle enable strobe, both at any integer ratio. It supports glitch-free ratio changes at period boundaries and three run modes: free-run, fixed edge budget, and run-until-end. It also counts UUT edges so the FSM can log performance figures.

---
 rtl/uut_clk_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uut_clk_ctrl.sv
// uut_clk_ctrl: divides the system clock into a registered UUT clock with a
// matching one-cycle enable strobe, runs in free-run, edge-budget or
// run-until-end mode, and counts the UUT rising edges it issues.
module uut_clk_ctrl #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [1:0]       mode_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [CNT_W-1:0] budget_i,
   input  logic             end_uut_i,
   output logic             uut_clk_o,
   output logic             uut_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cycles_o,
   output logic             overflow_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [1:0] MODE_FREE   = 2'd0;
   localparam logic [1:0] MODE_BUDGET = 2'd1;
   localparam logic [1:0] MODE_UNTIL  = 2'd2;

   state_t           state;
   state_t           state_next;
   logic [DIV_W-1:0] ph;
   logic [DIV_W-1:0] ph_next;
   logic [DIV_W-1:0] d_q;
   logic [DIV_W-1:0] d_next;
   logic [DIV_W-1:0] d_in;
   logic [DIV_W:0]   half_next;
   logic [1:0]       mode_q;
   logic [1:0]       mode_in;
   logic [CNT_W-1:0] budget_q;
   logic             start_load;
   logic             done_next;
   logic             clk_next;
   logic             en_next;
   logic             last_ph;
   logic             stop_cond;

   // Ratios below 2 cannot produce both a high and a low phase, so clamp to 2.
   assign d_in    = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
   // Mode 3 is reserved and behaves as free-run.
   assign mode_in = (mode_i == 2'd3) ? MODE_FREE : mode_i;
   assign last_ph = (ph == (d_q - DIV_W'(1)));

   // The budget stop fires while the final allowed strobe is on the output,
   // so no later strobe is ever issued.
   assign stop_cond = stop_i
                    | ((mode_q == MODE_UNTIL) & end_uut_i)
                    | ((mode_q == MODE_BUDGET) & uut_en_o
                       & (cycles_o == (budget_q - CNT_W'(1))));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, next phase/ratio and the values the output flops will load.
   always_comb begin
      state_next = state;
      ph_next    = ph;
      d_next     = d_q;
      done_next  = 1'b0;
      start_load = 1'b0;
      half_next  = '0;
      clk_next   = 1'b0;
      en_next    = 1'b0;

      case (state)
         IDLE: begin
            ph_next = '0;
            if (start_i) begin
               start_load = 1'b1;
               if ((mode_in == MODE_BUDGET) && (budget_i == '0)) begin
                  done_next = 1'b1;
               end else begin
                  state_next = RUN;
                  d_next     = d_in;
               end
            end
         end
         RUN: begin
            if (stop_cond) begin
               if (last_ph) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
                  ph_next    = '0;
               end else begin
                  state_next = STOP;
                  ph_next    = ph + DIV_W'(1);
               end
            end else if (last_ph) begin
               ph_next = '0;
               d_next  = d_in;
            end else begin
               ph_next = ph + DIV_W'(1);
            end
         end
         STOP: begin
            if (last_ph) begin
               state_next = IDLE;
               done_next  = 1'b1;
               ph_next    = '0;
            end else begin
               ph_next = ph + DIV_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            ph_next    = '0;
         end
      endcase

      half_next = ({1'b0, d_next} + (DIV_W+1)'(1)) >> 1;
      clk_next  = (state_next != IDLE) && ({1'b0, ph_next} < half_next);
      en_next   = (state_next == RUN) && (ph_next == '0);
   end

   // Phase, ratio, registered outputs and the latched run parameters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph         <= '0;
         d_q        <= DIV_W'(2);
         mode_q     <= MODE_FREE;
         budget_q   <= '0;
         uut_clk_o  <= 1'b0;
         uut_en_o   <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         cycles_o   <= '0;
         overflow_o <= 1'b0;
      end else begin
         ph        <= ph_next;
         d_q       <= d_next;
         uut_clk_o <= clk_next;
         uut_en_o  <= en_next;
         busy_o    <= (state_next != IDLE);
         done_o    <= done_next;
         if (start_load) begin
            mode_q     <= mode_in;
            budget_q   <= budget_i;
            cycles_o   <= '0;
            overflow_o <= 1'b0;
         end else if (uut_en_o) begin
            if (cycles_o == {CNT_W{1'b1}}) begin
               overflow_o <= 1'b1;
            end else begin
               cycles_o <= cycles_o + CNT_W'(1);
            end
         end
      end
   end

endmodule
